// File: rtl/hdlc_line_monitor.sv
// Run-time HDLC line checker: flag/abort/idle detection, receiver strobe latency
// checks, sticky error flags and a saturating error counter. Define
// HDLC_MON_ALIGN_EN to build the payload byte-alignment checker.
module hdlc_line_monitor #(
  parameter int NCH       = 1,
  parameter int FLAG_LAT  = 2,
  parameter int ABORT_LAT = 2,
  parameter int IDLE_ONES = 15,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Enable,
  input  logic             ClearErr,
  input  logic [NCH-1:0]   Line,
  input  logic [NCH-1:0]   DutFlag,
  input  logic [NCH-1:0]   DutAbort,
  output logic [NCH-1:0]   ErrFlagMiss,
  output logic [NCH-1:0]   ErrAbortMiss,
  output logic [NCH-1:0]   ErrSpurious,
  output logic [NCH-1:0]   ErrAlign,
  output logic [NCH-1:0]   FrameOpen,
  output logic [CNT_W-1:0] ErrCnt
);

  // state     | meaning
  // S_IDLE    | line idle (IDLE_ONES ones seen) or monitor disabled
  // S_OPEN    | inside a frame, after an opening flag
  // S_ABORTED | abort seen, waiting for the next flag
  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_ABORTED} state_t;

  // Wide enough for the counter plus a per-cycle sum of up to 64 events.
  localparam int ACC_W = CNT_W + 8;
  localparam logic [ACC_W-1:0] CNT_MAX = {{8{1'b0}}, {CNT_W{1'b1}}};

  state_t               state    [NCH];
  logic [4:0]           ones     [NCH];
  logic [4:0]           ones_nx  [NCH];
  logic [FLAG_LAT-1:0]  fpipe    [NCH];
  logic [FLAG_LAT-1:0]  fpipe_nx [NCH];
  logic [ABORT_LAT-1:0] apipe    [NCH];
  logic [ABORT_LAT-1:0] apipe_nx [NCH];
  logic [NCH-1:0]       seen_zero;
  logic [NCH-1:0]       flag_ev, abort_ev;
  logic [NCH-1:0]       miss_f, miss_a, spur, align_ev;
  logic [ACC_W-1:0]     ev_sum, acc;

  always_comb begin
    flag_ev  = '0;
    abort_ev = '0;
    miss_f   = '0;
    miss_a   = '0;
    spur     = '0;
    for (int i = 0; i < NCH; i++) begin
      flag_ev[i]  = Enable & ~Line[i] & seen_zero[i] & (ones[i] == 5'd6);
      abort_ev[i] = Enable &  Line[i] & seen_zero[i] & (ones[i] == 5'd6);
      if (!Line[i])
        ones_nx[i] = 5'd0;
      else if (ones[i] == 5'd31)
        ones_nx[i] = 5'd31;
      else
        ones_nx[i] = ones[i] + 5'd1;
      fpipe_nx[i]    = fpipe[i] << 1;
      fpipe_nx[i][0] = flag_ev[i];
      apipe_nx[i]    = apipe[i] << 1;
      apipe_nx[i][0] = abort_ev[i];
      miss_f[i] = Enable & fpipe[i][FLAG_LAT-1] & ~DutFlag[i];
      miss_a[i] = Enable & apipe[i][ABORT_LAT-1] & ~DutAbort[i];
      spur[i]   = Enable & ((DutFlag[i] & ~fpipe[i][FLAG_LAT-1]) |
                            (DutAbort[i] & ~apipe[i][ABORT_LAT-1]));
    end
  end

  always_comb begin
    ev_sum = '0;
    for (int i = 0; i < NCH; i++)
      ev_sum = ev_sum + ACC_W'(miss_f[i]) + ACC_W'(miss_a[i]) +
               ACC_W'(spur[i]) + ACC_W'(align_ev[i]);
    acc = ACC_W'(ErrCnt) + ev_sum;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NCH; i++) begin
        state[i] <= S_IDLE;
        ones[i]  <= '0;
        fpipe[i] <= '0;
        apipe[i] <= '0;
      end
      seen_zero    <= '0;
      FrameOpen    <= '0;
      ErrFlagMiss  <= '0;
      ErrAbortMiss <= '0;
      ErrSpurious  <= '0;
      ErrCnt       <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!Enable) begin
          state[i]     <= S_IDLE;
          FrameOpen[i] <= 1'b0;
          ones[i]      <= '0;
          seen_zero[i] <= 1'b0;
          fpipe[i]     <= '0;
          apipe[i]     <= '0;
        end else begin
          ones[i]      <= ones_nx[i];
          seen_zero[i] <= seen_zero[i] | ~Line[i];
          fpipe[i]     <= fpipe_nx[i];
          apipe[i]     <= apipe_nx[i];
          // Idle detection overrides everything; events never coincide with it.
          if (ones_nx[i] >= 5'(IDLE_ONES)) begin
            state[i]     <= S_IDLE;
            FrameOpen[i] <= 1'b0;
          end else if (flag_ev[i]) begin
            state[i]     <= S_OPEN;
            FrameOpen[i] <= 1'b1;
          end else if (abort_ev[i] && state[i] != S_ABORTED) begin
            state[i]     <= S_ABORTED;
            FrameOpen[i] <= 1'b0;
          end
        end
      end

      if (ClearErr) begin
        ErrFlagMiss  <= '0;
        ErrAbortMiss <= '0;
        ErrSpurious  <= '0;
        ErrCnt       <= '0;
      end else begin
        ErrFlagMiss  <= ErrFlagMiss  | miss_f;
        ErrAbortMiss <= ErrAbortMiss | miss_a;
        ErrSpurious  <= ErrSpurious  | spur;
        ErrCnt       <= (acc > CNT_MAX) ? {CNT_W{1'b1}} : acc[CNT_W-1:0];
      end
    end
  end

`ifdef HDLC_MON_ALIGN_EN
  // bit_cnt[3] latches "at least 8", bit_cnt[2:0] is the count modulo 8.
  logic [3:0] bit_cnt [NCH];

  always_comb begin
    align_ev = '0;
    for (int i = 0; i < NCH; i++)
      align_ev[i] = flag_ev[i] & (state[i] == S_OPEN) & bit_cnt[i][3] &
                    (bit_cnt[i][2:0] != 3'd7);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NCH; i++)
        bit_cnt[i] <= '0;
      ErrAlign <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!Enable || flag_ev[i])
          bit_cnt[i] <= '0;
        else if (state[i] == S_OPEN && !(!Line[i] && ones[i] == 5'd5))
          bit_cnt[i] <= {bit_cnt[i][3] | (bit_cnt[i][2:0] == 3'd7),
                         bit_cnt[i][2:0] + 3'd1};
      end
      if (ClearErr)
        ErrAlign <= '0;
      else
        ErrAlign <= ErrAlign | align_ev;
    end
  end
`else
  assign align_ev = '0;
  assign ErrAlign = '0;
`endif

endmodule

// File: tb/tb_hdlc_line_monitor.sv
// Directed bench for hdlc_line_monitor: a default 1-channel instance and a
// 4-channel instance with a 4-bit counter for saturation and clear checks.
module tb_hdlc_line_monitor;

`ifdef HDLC_MON_ALIGN_EN
  localparam logic ALIGN = 1'b1;
`else
  localparam logic ALIGN = 1'b0;
`endif

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Rst, Enable, ClearErr;

  logic [0:0]  a_line, a_flag, a_abort;
  logic [0:0]  a_fmiss, a_amiss, a_spur, a_align, a_open;
  logic [15:0] a_cnt;

  logic [3:0]  b_line, b_flag, b_abort;
  logic [3:0]  b_fmiss, b_amiss, b_spur, b_align, b_open;
  logic [3:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  hdlc_line_monitor dut_a (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .ClearErr(ClearErr),
    .Line(a_line), .DutFlag(a_flag), .DutAbort(a_abort),
    .ErrFlagMiss(a_fmiss), .ErrAbortMiss(a_amiss), .ErrSpurious(a_spur),
    .ErrAlign(a_align), .FrameOpen(a_open), .ErrCnt(a_cnt)
  );

  hdlc_line_monitor #(.NCH(4), .CNT_W(4)) dut_b (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .ClearErr(ClearErr),
    .Line(b_line), .DutFlag(b_flag), .DutAbort(b_abort),
    .ErrFlagMiss(b_fmiss), .ErrAbortMiss(b_amiss), .ErrSpurious(b_spur),
    .ErrAlign(b_align), .FrameOpen(b_open), .ErrCnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic l, input logic f, input logic ab);
    a_line[0]  = l;
    a_flag[0]  = f;
    a_abort[0] = ab;
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--)
      step(v[i], 1'b0, 1'b0);
  endtask

  // 0 then 0111111 0; the receiver strobe (if any) lands 2 cycles after the last 0.
  task automatic flag_seq(input logic pulse);
    step(1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, pulse, 1'b0);
  endtask

  task automatic restart_clear();
    Enable = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    Enable   = 1'b1;
    ClearErr = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    ClearErr = 1'b0;
  endtask

  initial begin
    Rst = 1'b0; Enable = 1'b0; ClearErr = 1'b0;
    a_line = 1'b1; a_flag = 1'b0; a_abort = 1'b0;
    b_line = 4'hF; b_flag = 4'h0; b_abort = 4'h0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_open", a_open, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_b_cnt", b_cnt, 0);
    Rst = 1'b1;

    // Idle line
    Enable = 1'b1;
    repeat (20) step(1'b1, 1'b0, 1'b0);
    chk("idle_open", a_open, 0);
    chk("idle_errs", {a_fmiss, a_amiss, a_spur, a_align}, 0);
    chk("idle_cnt", a_cnt, 0);
    chk("idle_b_cnt", b_cnt, 0);

    // Flag with on-time strobe
    restart_clear();
    flag_seq(1'b1);
    chk("flag_ok_open", a_open, 1);
    chk("flag_ok_errs", {a_fmiss, a_spur}, 0);
    chk("flag_ok_cnt", a_cnt, 0);

    // Flag with strobe one cycle late
    restart_clear();
    flag_seq(1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("flag_late_miss", a_fmiss, 1);
    chk("flag_late_spur", a_spur, 1);
    chk("flag_late_cnt", a_cnt, 2);

    restart_clear();
    chk("clear_errs", {a_fmiss, a_amiss, a_spur}, 0);
    chk("clear_cnt", a_cnt, 0);

    // Unexpected abort strobe
    step(1'b1, 1'b0, 1'b1);
    chk("abort_spur", a_spur, 1);
    chk("abort_spur_cnt", a_cnt, 1);

    // Abort inside a frame with on-time strobe
    restart_clear();
    flag_seq(1'b1);
    step(1'b0, 1'b0, 1'b0);
    repeat (7) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("abort_ok_open", a_open, 0);
    chk("abort_ok_errs", {a_amiss, a_spur, a_align}, 0);
    chk("abort_ok_cnt", a_cnt, 0);
    step(1'b0, 1'b0, 1'b0);

    // Abort without strobe
    restart_clear();
    flag_seq(1'b1);
    step(1'b0, 1'b0, 1'b0);
    repeat (7) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("abort_miss", a_amiss, 1);
    chk("abort_miss_cnt", a_cnt, 1);
    chk("abort_miss_open", a_open, 0);

    // 16 payload bits including a stuffed zero
    restart_clear();
    flag_seq(1'b1);
    send(32'b11111_0_010100100, 15);
    flag_seq(1'b1);
    chk("align16_err", a_align, 0);
    chk("align16_cnt", a_cnt, 0);
    chk("align16_open", a_open, 1);

    // 13 payload bits
    restart_clear();
    flag_seq(1'b1);
    send(32'b10101010100, 11);
    flag_seq(1'b1);
    chk("align13_err", a_align, 32'(ALIGN));
    chk("align13_cnt", a_cnt, 32'(ALIGN));

    // Back-to-back flags sharing a zero: empty frame, no alignment check
    restart_clear();
    step(1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("b2b_errs", {a_fmiss, a_spur, a_align}, 0);
    chk("b2b_open", a_open, 1);

    // 4-channel counter saturation: four rounds of misses on all channels
    restart_clear();
    b_line = 4'h0;
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      b_line = 4'hF;
      repeat (6) step(1'b1, 1'b0, 1'b0);
      b_line = 4'h0;
      step(1'b1, 1'b0, 1'b0);
      chk("b_cnt_ramp", b_cnt, 32'(4 * k));
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("b_cnt_sat", b_cnt, 15);
    chk("b_miss_all", b_fmiss, 4'hF);

    // Clear in the same cycle as a new miss
    b_line = 4'hF;
    repeat (6) step(1'b1, 1'b0, 1'b0);
    b_line = 4'h0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    ClearErr = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    ClearErr = 1'b0;
    chk("b_clr_cnt", b_cnt, 0);
    chk("b_clr_miss", b_fmiss, 0);
    step(1'b1, 1'b0, 1'b0);
    chk("b_clr_hold", b_cnt, 0);
    b_line = 4'hF;

    // Async reset mid-frame
    restart_clear();
    flag_seq(1'b0);
    chk("pre_rst_open", a_open, 1);
    chk("pre_rst_miss", a_fmiss, 1);
    #2 Rst = 1'b0;
    #1;
    chk("async_open", a_open, 0);
    chk("async_miss", a_fmiss, 0);
    chk("async_cnt", a_cnt, 0);
    @(posedge Clk);
    #1 Rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
